// File: rtl/shift_add_mult.sv
// Iterative unsigned WIDTHxWIDTH shift-and-add multiplier. It drives an external
// carry-lookahead adder and folds the adder's sum and carry-out back in on every step.
module shift_add_mult #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_ci,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_co
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mc_q, mc_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE accepts a new start just like IDLE, which is what allows back-to-back runs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        add_a  = '0;
        add_b  = '0;
        add_ci = 1'b0;
        case (state_q)
            RUN: begin
                busy  = 1'b1;
                add_a = acc_hi_q;
                add_b = acc_lo_q[0] ? mc_q : '0;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // The carry-out becomes the new top bit of the 65-bit partial product before the shift.
    always_comb begin
        mc_d      = mc_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (state_q == RUN) begin
            {acc_hi_d, acc_lo_d} = {add_co, add_sum, acc_lo_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                product_d = {add_co, add_sum, acc_lo_q[WIDTH-1:1]};
            end
        end else if (start) begin
            mc_d     = mcand;
            acc_hi_d = '0;
            acc_lo_d = mplier;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_q      <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            mc_q      <= mc_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule
